// File: rtl/ifu_fetch.sv
// Instruction fetch unit: generates the fetch PC, issues aligned 8-byte
// ICache requests (one outstanding at most) and splits each response into
// IF_WIDTH instruction slots for the instruction buffer.

package ifu_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } instr_info_t;
endpackage

module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IF_WIDTH   = 2,   // only 2 is supported
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           icache_req_valid_o,
  input  logic                           icache_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          icache_req_addr_o,
  input  logic                           icache_resp_valid_i,
  input  logic [63:0]                    icache_resp_data_i,
  input  logic                           stallreq_i,
  input  logic                           redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]          redirect_pc_i,
  output instr_info_t [IF_WIDTH-1:0]     instr_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e                       state_q;
  logic [ADDR_WIDTH-1:0]        pc_q;
  logic                         req_valid_q;
  instr_info_t [IF_WIDTH-1:0]   instr_q;
  instr_info_t [IF_WIDTH-1:0]   slot_d;
  logic [ADDR_WIDTH-1:0]        line_pc;

  // The request address is the 8-byte line containing pc; it only moves on
  // redirect (which withdraws the request) or on delivery, so it is stable in REQ.
  assign line_pc            = {pc_q[ADDR_WIDTH-1:3], 3'b000};
  assign icache_req_addr_o  = line_pc;
  assign icache_req_valid_o = req_valid_q;
  assign instr_o            = instr_q;

  // Slot split: slot i takes word (pc[2]+i) of the line; words past the end
  // of the line leave the slot invalid, so valid slots pack from slot 0.
  always_comb begin
    slot_d = '0;
    for (int i = 0; i < IF_WIDTH; i++) begin
      int widx;
      widx = int'(pc_q[2]) + i;
      if (widx < 2) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].pc    = pc_q + ADDR_WIDTH'(4 * i);
        slot_d[i].instr = (widx == 0) ? icache_resp_data_i[31:0]
                                      : icache_resp_data_i[63:32];
      end
    end
  end

  // Fetch FSM with registered request valid and delivery slots; redirect
  // always reloads pc and wins over every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      instr_q     <= '0;
    end else begin
      instr_q <= '0;
      if (redirect_valid_i) pc_q <= redirect_pc_i;
      case (state_q)
        IDLE: begin
          if (!redirect_valid_i && !stallreq_i) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end
        REQ: begin
          // Stall never withdraws a posted request; only redirect does.
          if (redirect_valid_i) begin
            req_valid_q <= 1'b0;
            state_q     <= icache_req_ready_i ? DROP : IDLE;
          end else if (icache_req_ready_i) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (icache_resp_valid_i) begin
            if (!redirect_valid_i) begin
              // The buffer guarantees headroom, so delivery ignores stall.
              instr_q <= slot_d;
              pc_q    <= line_pc + ADDR_WIDTH'(8);
              if (!stallreq_i) begin
                state_q     <= REQ;
                req_valid_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= IDLE;
            end
          end else if (redirect_valid_i) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          // Swallow the response of the abandoned request.
          if (icache_resp_valid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: per-cycle vector table for request outputs, with
// expected deliveries queued on the response cycle and checked one cycle later.

module tb_ifu_fetch;
  import ifu_pkg::*;

  logic                    clk, rst_n;
  logic                    req_valid, req_ready, resp_valid, stallreq, redir;
  logic [31:0]             req_addr, redir_pc;
  logic [63:0]             resp_data;
  instr_info_t [1:0]       instr;

  ifu_fetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_req_valid_o  (req_valid),
    .icache_req_ready_i  (req_ready),
    .icache_req_addr_o   (req_addr),
    .icache_resp_valid_i (resp_valid),
    .icache_resp_data_i  (resp_data),
    .stallreq_i          (stallreq),
    .redirect_valid_i    (redir),
    .redirect_pc_i       (redir_pc),
    .instr_o             (instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, resp, stall, redir;
    logic [31:0] rpc;
    logic [63:0] data;
    logic        ereq;
    logic [31:0] eaddr;
    logic        dlv;
    logic [31:0] dpc;
  } vec_t;

  typedef struct {
    int                due;
    instr_info_t [1:0] slots;
  } sb_t;

  localparam int NV = 40;
  vec_t tbl [NV];
  sb_t  sbq [$];
  int   checks = 0, failures = 0;

  localparam logic [63:0] D0 = 64'hBBBB_BBBB_AAAA_AAAA;
  localparam logic [63:0] D1 = 64'h2222_2222_1111_1111;
  localparam logic [63:0] D2 = 64'h4444_4444_3333_3333;
  localparam logic [63:0] D3 = 64'h6666_6666_5555_5555;
  localparam logic [63:0] D4 = 64'hDEAD_DEAD_0BAD_0BAD;
  localparam logic [63:0] D5 = 64'hCAFE_CAFE_F00D_F00D;
  localparam logic [63:0] D6 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] D7 = 64'h8888_8888_7777_7777;

  function automatic vec_t v(logic rdy, logic resp, logic [63:0] data, logic stall,
                             logic rd, logic [31:0] rpc, logic ereq, logic [31:0] eaddr,
                             logic dlv, logic [31:0] dpc);
    vec_t t;
    t.rdy = rdy; t.resp = resp; t.data = data; t.stall = stall; t.redir = rd;
    t.rpc = rpc; t.ereq = ereq; t.eaddr = eaddr; t.dlv = dlv; t.dpc = dpc;
    return t;
  endfunction

  // Reference slot split for a delivered line.
  function automatic instr_info_t [1:0] exp_slots(logic [31:0] pc, logic [63:0] d);
    instr_info_t [1:0] s;
    s = '0;
    s[0].valid = 1'b1;
    s[0].pc    = pc;
    if (!pc[2]) begin
      s[0].instr = d[31:0];
      s[1].valid = 1'b1;
      s[1].pc    = pc + 32'd4;
      s[1].instr = d[63:32];
    end else begin
      s[0].instr = d[63:32];
    end
    return s;
  endfunction

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One table row: drive after posedge, check at negedge, queue delivery.
  task automatic run_rows(int lo, int hi);
    for (int r = lo; r <= hi; r++) begin
      @(posedge clk); #1;
      req_ready  = tbl[r].rdy;
      resp_valid = tbl[r].resp;
      resp_data  = tbl[r].data;
      stallreq   = tbl[r].stall;
      redir      = tbl[r].redir;
      redir_pc   = tbl[r].rpc;
      @(negedge clk);
      chk($sformatf("req_valid row%0d", r), 160'(req_valid), 160'(tbl[r].ereq));
      chk($sformatf("req_addr row%0d", r), 160'(req_addr), 160'(tbl[r].eaddr));
      if (sbq.size() > 0 && sbq[0].due == r) begin
        chk($sformatf("delivery row%0d", r), 160'(instr), 160'(sbq[0].slots));
        void'(sbq.pop_front());
      end else begin
        chk($sformatf("idle_slots row%0d", r), 160'(instr), 160'(0));
      end
      if (tbl[r].dlv) sbq.push_back('{due: r + 1, slots: exp_slots(tbl[r].dpc, tbl[r].data)});
    end
  endtask

  localparam logic [31:0] RP = 32'h1c000000;

  initial begin
    //             rdy resp data stall redir rpc           ereq eaddr         dlv dpc
    tbl[0]  = v(0, 0, 0,  0, 0, 0,            0, RP,            0, 0);
    tbl[1]  = v(1, 0, 0,  0, 0, 0,            1, RP,            0, 0);
    tbl[2]  = v(0, 1, D0, 0, 0, 0,            0, RP,            1, RP);
    tbl[3]  = v(1, 0, 0,  0, 0, 0,            1, 32'h1c000008,  0, 0);
    tbl[4]  = v(0, 1, D1, 1, 0, 0,            0, 32'h1c000008,  1, 32'h1c000008);
    tbl[5]  = v(0, 0, 0,  0, 1, 32'h1c000104, 0, 32'h1c000010,  0, 0);
    tbl[6]  = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000100,  0, 0);
    tbl[7]  = v(1, 0, 0,  0, 0, 0,            1, 32'h1c000100,  0, 0);
    tbl[8]  = v(0, 1, D2, 0, 0, 0,            0, 32'h1c000100,  1, 32'h1c000104);
    tbl[9]  = v(1, 0, 0,  0, 0, 0,            1, 32'h1c000108,  0, 0);
    tbl[10] = v(0, 0, 0,  1, 0, 0,            0, 32'h1c000108,  0, 0);
    tbl[11] = v(0, 1, D3, 1, 0, 0,            0, 32'h1c000108,  1, 32'h1c000108);
    tbl[12] = v(0, 0, 0,  1, 0, 0,            0, 32'h1c000110,  0, 0);
    tbl[13] = v(0, 0, 0,  1, 0, 0,            0, 32'h1c000110,  0, 0);
    tbl[14] = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000110,  0, 0);
    tbl[15] = v(1, 0, 0,  0, 0, 0,            1, 32'h1c000110,  0, 0);
    tbl[16] = v(0, 0, 0,  0, 1, 32'h1c000200, 0, 32'h1c000110,  0, 0);
    tbl[17] = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000200,  0, 0);
    tbl[18] = v(0, 1, D4, 0, 0, 0,            0, 32'h1c000200,  0, 0);
    tbl[19] = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000200,  0, 0);
    tbl[20] = v(0, 0, 0,  0, 0, 0,            1, 32'h1c000200,  0, 0);
    tbl[21] = v(0, 0, 0,  1, 0, 0,            1, 32'h1c000200,  0, 0);
    tbl[22] = v(0, 0, 0,  0, 1, 32'h1c000300, 1, 32'h1c000200,  0, 0);
    tbl[23] = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000300,  0, 0);
    tbl[24] = v(1, 0, 0,  0, 1, 32'h1c000404, 1, 32'h1c000300,  0, 0);
    tbl[25] = v(0, 1, D5, 0, 1, 32'h1c000504, 0, 32'h1c000400,  0, 0);
    tbl[26] = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000500,  0, 0);
    tbl[27] = v(1, 0, 0,  0, 0, 0,            1, 32'h1c000500,  0, 0);
    tbl[28] = v(0, 1, D6, 0, 1, 32'h1c000600, 0, 32'h1c000500,  0, 0);
    tbl[29] = v(0, 0, 0,  1, 0, 0,            0, 32'h1c000600,  0, 0);
    tbl[30] = v(0, 0, 0,  0, 1, 32'hFFFFFFFC, 0, 32'h1c000600,  0, 0);
    tbl[31] = v(0, 0, 0,  0, 0, 0,            0, 32'hFFFFFFF8,  0, 0);
    tbl[32] = v(1, 0, 0,  0, 0, 0,            1, 32'hFFFFFFF8,  0, 0);
    tbl[33] = v(0, 1, D7, 0, 0, 0,            0, 32'hFFFFFFF8,  1, 32'hFFFFFFFC);
    tbl[34] = v(0, 0, 0,  0, 1, 32'h1c000700, 1, 32'h00000000,  0, 0);
    tbl[35] = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000700,  0, 0);
    tbl[36] = v(1, 0, 0,  0, 0, 0,            1, 32'h1c000700,  0, 0);
    tbl[37] = v(0, 0, 0,  0, 0, 0,            0, 32'h1c000700,  0, 0);
    tbl[38] = v(0, 0, 0,  0, 0, 0,            0, RP,            0, 0);
    tbl[39] = v(0, 0, 0,  0, 0, 0,            1, RP,            0, 0);

    // Reset state, with stall high so nothing issues at release.
    rst_n = 1'b0; req_ready = 0; resp_valid = 0; resp_data = '0;
    stallreq = 1'b1; redir = 0; redir_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_valid", 160'(req_valid), 160'(0));
    chk("reset req_addr", 160'(req_addr), 160'(RP));
    chk("reset slots", 160'(instr), 160'(0));
    #2 rst_n = 1'b1;

    run_rows(0, 37);

    // Reset pulse while waiting on a response: state and pc return at once.
    #2;
    rst_n = 1'b0; stallreq = 1'b1; req_ready = 0; resp_valid = 0; redir = 0;
    #1;
    chk("midreset req_valid", 160'(req_valid), 160'(0));
    chk("midreset req_addr", 160'(req_addr), 160'(RP));
    chk("midreset slots", 160'(instr), 160'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    run_rows(38, 39);

    chk("scoreboard drained", 160'(sbq.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
